// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Types and constants shared by the PPU neighbour-exchange logic.
//   PPU_TILE_SIZE / PPU_DATA_WIDTH / PPU_CW : default tile geometry
//   NEIGHBOR_COUNT : number of halo links per PPU (one per direction)
//   halo_entry_t   : one buffered halo partial sum {value, row, column}
//   link_state_t   : exchange-link control states
// ---------------------------------------------------------------------------
package ppu_pkg;

    localparam int PPU_TILE_SIZE  = 256;
    localparam int PPU_DATA_WIDTH = 8;
    localparam int PPU_CW         = $clog2(PPU_TILE_SIZE);
    localparam int NEIGHBOR_COUNT = 8;

    typedef struct packed {
        logic [PPU_DATA_WIDTH-1:0] value;
        logic [PPU_CW-1:0]         row;
        logic [PPU_CW-1:0]         column;
    } halo_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } link_state_t;

    // Flattened width of one FIFO entry for a given geometry.
    function automatic int halo_entry_width(input int data_width, input int tile_size);
        return data_width + 2 * $clog2(tile_size);
    endfunction

endpackage

// File: rtl/halo_exchange_link_fifo.sv
// ---------------------------------------------------------------------------
// halo_fifo
// Synchronous FIFO with occupancy count and registered read data.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset (pointers, count, read data)
//   push_i    : write wdata_i at the write pointer (caller guarantees not full)
//   wdata_i   : entry to store
//   pop_i     : read entry at the read pointer (caller guarantees not empty)
//   rdata_o   : entry popped on the previous cycle; holds between pops
//   count_o   : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module halo_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    // Storage has no reset so it maps onto distributed/block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q,  count_d;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (pop_i) begin
                rdata_q <= mem[rd_ptr_q];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign count_o = count_q;

endmodule

// File: rtl/halo_exchange_link.sv
// ---------------------------------------------------------------------------
// halo_exchange_link
// One-direction halo channel between two adjacent PPU tiles. Buffers halo
// partial sums from the sender, delivers them to the receiver whenever it
// raises clear_to_send, and signals end-of-exchange once fully drained.
//   clk, reset_n          : clock / asynchronous active-low reset
//   tx_value/row/column   : sender halo entry
//   tx_write_enable       : sender push request
//   tx_exchange_done      : sender has finished producing halo entries
//   tx_cts                : push permitted (not full, still accepting)
//   rx_clear_to_send      : receiver ready to take an entry
//   rx_value/row/column   : delivered entry (registered, holds between pops)
//   rx_write_enable       : one-cycle strobe per delivered entry
//   rx_exchange_done      : level, high once drained until cycle_done
//   cycle_done            : global rearm, only honoured when done
//   protocol_error        : sticky, push attempted while tx_cts was low
// ---------------------------------------------------------------------------
module halo_exchange_link
    import ppu_pkg::*;
#(
    parameter  int TILE_SIZE  = 256,
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(TILE_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_value,
    input  logic [CW-1:0]         tx_row,
    input  logic [CW-1:0]         tx_column,
    input  logic                  tx_write_enable,
    input  logic                  tx_exchange_done,
    output logic                  tx_cts,
    input  logic                  rx_clear_to_send,
    output logic [DATA_WIDTH-1:0] rx_value,
    output logic [CW-1:0]         rx_row,
    output logic [CW-1:0]         rx_column,
    output logic                  rx_write_enable,
    output logic                  rx_exchange_done,
    input  logic                  cycle_done,
    output logic                  protocol_error
);

    localparam int EW   = DATA_WIDTH + 2 * CW;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

    link_state_t     state_q, state_d;
    logic            rx_we_q;
    logic            err_q, err_d;

    logic [CNTW-1:0] fifo_count;
    logic [EW-1:0]   fifo_rdata;
    logic [EW-1:0]   fifo_wdata;
    logic            push;
    logic            pop;
    logic            accepting;

    // Only registered state feeds tx_cts, so the sender never sees a
    // combinational loop through its own write_enable.
    assign accepting = (state_q == IDLE) || (state_q == XFER);
    assign tx_cts    = (fifo_count < FULL_COUNT) && accepting;

    assign push       = tx_write_enable && tx_cts;
    assign pop        = rx_clear_to_send && (fifo_count != '0);
    assign fifo_wdata = {tx_value, tx_row, tx_column};

    halo_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    // A push coincident with tx_exchange_done is still accepted because
    // tx_cts is evaluated from the pre-transition state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tx_exchange_done) begin
                    state_d = DRAIN;
                end else if (push) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tx_exchange_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Count is registered, so the last pop is already on the
                // rx lanes by the time this sees zero.
                if (fifo_count == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cycle_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_d = err_q | (tx_write_enable & ~tx_cts);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rx_we_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_we_q <= pop;
            err_q   <= err_d;
        end
    end

    assign rx_value         = fifo_rdata[EW-1 -: DATA_WIDTH];
    assign rx_row           = fifo_rdata[2*CW-1 -: CW];
    assign rx_column        = fifo_rdata[CW-1:0];
    assign rx_write_enable  = rx_we_q;
    assign rx_exchange_done = (state_q == DONE);
    assign protocol_error   = err_q;

endmodule

// File: tb/tb_halo_exchange_link.sv
module tb_halo_exchange_link;
    import ppu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_value = '0;
    logic [7:0] tx_row = '0;
    logic [7:0] tx_column = '0;
    logic       tx_write_enable = 1'b0;
    logic       tx_exchange_done = 1'b0;
    logic       tx_cts;
    logic       rx_clear_to_send = 1'b0;
    logic [7:0] rx_value;
    logic [7:0] rx_row;
    logic [7:0] rx_column;
    logic       rx_write_enable;
    logic       rx_exchange_done;
    logic       cycle_done = 1'b0;
    logic       protocol_error;

    int checks = 0;
    int failures = 0;

    halo_entry_t got[$];
    halo_entry_t exp_q[$];

    halo_exchange_link #(
        .TILE_SIZE  (256),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tx_value         (tx_value),
        .tx_row           (tx_row),
        .tx_column        (tx_column),
        .tx_write_enable  (tx_write_enable),
        .tx_exchange_done (tx_exchange_done),
        .tx_cts           (tx_cts),
        .rx_clear_to_send (rx_clear_to_send),
        .rx_value         (rx_value),
        .rx_row           (rx_row),
        .rx_column        (rx_column),
        .rx_write_enable  (rx_write_enable),
        .rx_exchange_done (rx_exchange_done),
        .cycle_done       (cycle_done),
        .protocol_error   (protocol_error)
    );

    always #5 clk = ~clk;

    // Receiver model: capture every delivered entry.
    always @(negedge clk) begin
        if (reset_n && rx_write_enable) begin
            got.push_back({rx_value, rx_row, rx_column});
        end
    end

    typedef struct {
        logic       we;
        logic [7:0] val;
        logic [7:0] row;
        logic [7:0] col;
        logic       xdone;
        logic       rcts;
        logic       cdone;
        logic       e_cts;
        logic       e_rwe;
        logic [7:0] e_val;
        logic [7:0] e_row;
        logic [7:0] e_col;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        tx_write_enable  = 1'b0;
        tx_exchange_done = 1'b0;
        tx_value         = '0;
        tx_row           = '0;
        tx_column        = '0;
        rx_clear_to_send = 1'b0;
        cycle_done       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        got.delete();
        exp_q.delete();
    endtask

    task automatic push_entry(input logic [7:0] v, input logic [7:0] r, input logic [7:0] c);
        tx_write_enable = 1'b1;
        tx_value        = v;
        tx_row          = r;
        tx_column       = c;
    endtask

    task automatic compare_queues(input string name);
        check($sformatf("%s_count", name), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_entry%0d", name, i), got[i], exp_q[i]);
        end
        $display("%s: delivered %0d entries, expected %0d", name, got.size(), exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    val    row   col   xd    rcts  cd    cts   rwe   val    row   col   done  err
        vecs[0] = '{1'b1, 8'h11, 8'd5, 8'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 8'd5, 8'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 8'd5, 8'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 8'd5, 8'd7, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 8'd5, 8'd8, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 8'd5, 8'd9, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'd5, 8'd9, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 8'd5, 8'd9, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 8'd5, 8'd9, 1'b0, 1'b0};

        // ---------------- Reset state + basic 3-entry exchange -----------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_write_enable  = vecs[i].we;
            tx_value         = vecs[i].val;
            tx_row           = vecs[i].row;
            tx_column        = vecs[i].col;
            tx_exchange_done = vecs[i].xdone;
            rx_clear_to_send = vecs[i].rcts;
            cycle_done       = vecs[i].cdone;
            #1;
            check($sformatf("vec%0d_tx_cts", i), tx_cts, vecs[i].e_cts);
            check($sformatf("vec%0d_rx_we", i), rx_write_enable, vecs[i].e_rwe);
            check($sformatf("vec%0d_rx_value", i), rx_value, vecs[i].e_val);
            check($sformatf("vec%0d_rx_row", i), rx_row, vecs[i].e_row);
            check($sformatf("vec%0d_rx_column", i), rx_column, vecs[i].e_col);
            check($sformatf("vec%0d_rx_done", i), rx_exchange_done, vecs[i].e_done);
            check($sformatf("vec%0d_perr", i), protocol_error, vecs[i].e_err);
            $display("vec%0d: cts=%0b rx_we=%0b rx=%02h/%0d/%0d done=%0b err=%0b", i, tx_cts,
                     rx_write_enable, rx_value, rx_row, rx_column, rx_exchange_done, protocol_error);
        end
        idle_inputs();

        // ---------------- Fill to full, overflow, drain 8 -----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            push_entry(8'(8'hA0 + i), 8'(i * 3), 8'(i));
            exp_q.push_back({8'(8'hA0 + i), 8'(i * 3), 8'(i)});
            #1;
            check($sformatf("t2_cts_before_push%0d", i), tx_cts, 1'b1);
        end
        @(negedge clk);
        push_entry(8'h99, 8'd1, 8'd1);
        #1;
        check("t2_cts_full", tx_cts, 1'b0);
        @(negedge clk);
        tx_write_enable = 1'b0;
        #1;
        check("t2_perr_after_overflow", protocol_error, 1'b1);
        check("t2_no_early_rx", rx_write_enable, 1'b0);
        rx_clear_to_send = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        check("t2_cts_after_drain", tx_cts, 1'b1);
        compare_queues("t2_drain");
        idle_inputs();

        // ---------------- Full + simultaneous push/pop, pointer wrap ------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            push_entry(8'(i * 7 + 1), 8'(i), 8'(255 - i));
            exp_q.push_back({8'(i * 7 + 1), 8'(i), 8'(255 - i)});
        end
        @(negedge clk);
        push_entry(8'hEE, 8'hEE, 8'hEE);
        rx_clear_to_send = 1'b1;
        #1;
        check("t3_cts_full_with_pop", tx_cts, 1'b0);
        for (int i = 8; i < 20; i++) begin
            @(negedge clk);
            push_entry(8'(i * 7 + 1), 8'(i), 8'(255 - i));
            exp_q.push_back({8'(i * 7 + 1), 8'(i), 8'(255 - i)});
            #1;
            check($sformatf("t3_cts_count7_push%0d", i), tx_cts, 1'b1);
        end
        @(negedge clk);
        tx_write_enable = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("t3_perr_sticky", protocol_error, 1'b1);
        compare_queues("t3_wrap");
        idle_inputs();

        // ---------------- Empty exchange ---------------------------------
        do_reset();
        @(negedge clk);
        tx_exchange_done = 1'b1;
        rx_clear_to_send = 1'b1;
        #1;
        check("t4_done_at_T", rx_exchange_done, 1'b0);
        @(negedge clk);
        tx_exchange_done = 1'b0;
        #1;
        check("t4_done_at_T1", rx_exchange_done, 1'b0);
        check("t4_cts_drain", tx_cts, 1'b0);
        @(negedge clk);
        #1;
        check("t4_done_at_T2", rx_exchange_done, 1'b1);
        check("t4_no_rx_we", got.size(), 0);
        @(negedge clk);
        cycle_done = 1'b1;
        #1;
        check("t4_done_held", rx_exchange_done, 1'b1);
        @(negedge clk);
        cycle_done = 1'b0;
        #1;
        check("t4_done_cleared", rx_exchange_done, 1'b0);
        check("t4_cts_rearmed", tx_cts, 1'b1);
        $display("t4: empty exchange done=%0b cts=%0b", rx_exchange_done, tx_cts);
        idle_inputs();

        // ---------------- Push with done, push during DRAIN ---------------
        do_reset();
        @(negedge clk);
        push_entry(8'h5A, 8'd10, 8'd20);
        exp_q.push_back({8'h5A, 8'd10, 8'd20});
        @(negedge clk);
        push_entry(8'h6B, 8'd11, 8'd21);
        tx_exchange_done = 1'b1;
        exp_q.push_back({8'h6B, 8'd11, 8'd21});
        #1;
        check("t5_cts_with_done", tx_cts, 1'b1);
        @(negedge clk);
        tx_exchange_done = 1'b0;
        push_entry(8'h7C, 8'd12, 8'd22);
        #1;
        check("t5_cts_in_drain", tx_cts, 1'b0);
        @(negedge clk);
        tx_write_enable = 1'b0;
        #1;
        check("t5_perr_drain_push", protocol_error, 1'b1);
        rx_clear_to_send = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                #1;
                if (rx_exchange_done) begin
                    seen = 1'b1;
                    check("t5_delivered_before_done", got.size(), 2);
                    check("t5_no_we_with_done", rx_write_enable, 1'b0);
                    break;
                end
            end
            check("t5_done_seen", seen, 1'b1);
        end
        compare_queues("t5_drain");
        idle_inputs();

        // ---------------- Reset mid-DRAIN --------------------------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_entry(8'(8'hC0 + i), 8'(i + 40), 8'(i + 50));
        end
        @(negedge clk);
        tx_write_enable  = 1'b0;
        tx_exchange_done = 1'b1;
        @(negedge clk);
        tx_exchange_done = 1'b0;
        rx_clear_to_send = 1'b1;
        @(negedge clk);
        rx_clear_to_send = 1'b0;
        #1;
        check("t6_pre_reset_rx_we", rx_write_enable, 1'b1);
        check("t6_pre_reset_value", rx_value, 8'hC0);
        check("t6_pre_reset_cts", tx_cts, 1'b0);
        reset_n = 1'b0;
        #1;
        check("t6_reset_rx_we", rx_write_enable, 1'b0);
        check("t6_reset_rx_value", rx_value, 8'h00);
        check("t6_reset_rx_row", rx_row, 8'h00);
        check("t6_reset_rx_column", rx_column, 8'h00);
        check("t6_reset_rx_done", rx_exchange_done, 1'b0);
        check("t6_reset_perr", protocol_error, 1'b0);
        check("t6_reset_cts", tx_cts, 1'b1);
        got.delete();
        @(negedge clk);
        reset_n = 1'b1;
        rx_clear_to_send = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("t6_no_stale_entries", got.size(), 0);
        check("t6_cts_after_release", tx_cts, 1'b1);
        check("t6_done_after_release", rx_exchange_done, 1'b0);
        $display("t6: after reset delivered=%0d cts=%0b", got.size(), tx_cts);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
